// File: rtl/seq_adder.sv
// Multi-cycle unsigned adder: adds a+b CHUNK bits per cycle with a rippled carry flop.
// Define SEQ_ADDER_SUB_EN to add the sub port (a-b with borrow on overflow).
module seq_adder #(
    parameter int SIZE  = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
`ifdef SEQ_ADDER_SUB_EN
    input  logic            sub,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out,
    output logic            overflow
);

    localparam int unsigned NCH = SIZE / CHUNK;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    generate
        if ((SIZE % CHUNK) != 0) begin : g_chunk_check
            $error("seq_adder: SIZE must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state, state_n;
    logic            accept;
    logic            last;
    logic [SIZE-1:0] a_q, b_q;
    logic [SIZE-1:0] out_q;
    logic            ovf_q;
    logic            carry;
    logic [CW-1:0]   count;
    logic [CHUNK:0]  sum;
`ifdef SEQ_ADDER_SUB_EN
    logic            sub_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = ADD;
                end
            end
            ADD: begin
                if (last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand registers shift right each cycle so the current slice is always the low CHUNK bits.
    assign last = (count == LAST);
    assign sum  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
            carry <= 1'b0;
            count <= '0;
`ifdef SEQ_ADDER_SUB_EN
            sub_q <= 1'b0;
`endif
        end else if (accept) begin
            a_q   <= a;
            count <= '0;
`ifdef SEQ_ADDER_SUB_EN
            b_q   <= sub ? ~b : b;
            carry <= sub;
            sub_q <= sub;
`else
            b_q   <= b;
            carry <= 1'b0;
`endif
        end else if (state == ADD) begin
            a_q   <= a_q >> CHUNK;
            b_q   <= b_q >> CHUNK;
            carry <= sum[CHUNK];
            count <= count + 1'b1;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (count == CW'(i)) out_q[i*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
            end
            if (last) begin
`ifdef SEQ_ADDER_SUB_EN
                ovf_q <= sum[CHUNK] ^ sub_q;
`else
                ovf_q <= sum[CHUNK];
`endif
            end
        end
    end

    assign out      = out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_adder.sv
// Scoreboard bench for seq_adder: a 16/4 instance and an 8/8 (single-slice) instance.
module tb_seq_adder;

    typedef struct {
        logic [15:0] o;
        logic        v;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    logic        in_valid, in_ready, out_valid, out_ready, overflow, sub;
    logic [15:0] a, b, out;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, overflow1, sub1;
    logic [7:0]  a1, b1, out1;
    logic        pv0 = 1'b0;
    logic        pv1 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_adder #(.SIZE(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .overflow(overflow)
    );

    seq_adder #(.SIZE(8), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1),
`ifdef SEQ_ADDER_SUB_EN
        .sub(sub1),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1), .out(out1), .overflow(overflow1)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic timeout(input string nm);
        failures++;
        $display("FAIL %s timeout (t=%0t)", nm, $time);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send0(input logic [15:0] aa, input logic [15:0] bb, input logic s,
                         input logic [15:0] eo, input logic ev, input bit push);
        int n = 0;
        while (!in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) begin timeout("send0"); return; end
        end
        a = aa; b = bb; sub = s; in_valid = 1'b1;
        if (push) q0.push_back('{o: eo, v: ev, acc: cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    endtask

    task automatic send1(input logic [7:0] aa, input logic [7:0] bb);
        int n = 0;
        logic [8:0] s9;
        while (!in_ready1) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) begin timeout("send1"); return; end
        end
        s9 = {1'b0, aa} + {1'b0, bb};
        a1 = aa; b1 = bb; in_valid1 = 1'b1;
        q1.push_back('{o: {8'h00, s9[7:0]}, v: s9[8], acc: cyc + 1});
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        a1 = 8'($urandom); b1 = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q0.size() != 0 || q1.size() != 0) begin
            @(posedge clk); #1;
            n++;
            if (n > 500) begin
                timeout("drain");
                q0.delete(); q1.delete();
                return;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q0.size() == 0) begin
                chk("spurious_valid0", 1, 0);
            end else begin
                if (!pv0) chk("latency0", cyc - q0[0].acc, 4);
                chk("out0", int'(out), int'(q0[0].o));
                chk("ovf0", int'(overflow), int'(q0[0].v));
                chk("in_ready_done0", int'(in_ready), 0);
                if (out_ready) void'(q0.pop_front());
            end
        end
        pv0 <= rst_n && out_valid;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid1) begin
            if (q1.size() == 0) begin
                chk("spurious_valid1", 1, 0);
            end else begin
                if (!pv1) chk("latency1", cyc - q1[0].acc, 1);
                chk("out1", int'(out1), int'(q1[0].o[7:0]));
                chk("ovf1", int'(overflow1), int'(q1[0].v));
                if (out_ready1) void'(q1.pop_front());
            end
        end
        pv1 <= rst_n && out_valid1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; out_ready1 = 1'b1;
        #12;
        chk("rst_in_ready0", int'(in_ready), 1);
        chk("rst_out_valid0", int'(out_valid), 0);
        chk("rst_out0", int'(out), 0);
        chk("rst_ovf0", int'(overflow), 0);
        chk("rst_in_ready1", int'(in_ready1), 1);
        chk("rst_out_valid1", int'(out_valid1), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic adds, including a carry that ripples through every slice.
        send0(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1);
        send0(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
        send0(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        send0(16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b1);
        send0(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b1);
        drain();

        // Backpressure: result held, input pulses ignored.
        out_ready = 1'b0;
        send0(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!out_valid) timeout("bp_wait_valid");
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            a = 16'hFFFF; b = 16'hFFFF;
            @(posedge clk); #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("bp_no_extra_op", int'(out_valid), 0);

        // Reset in the middle of ADD aborts the operation.
        send0(16'h1234, 16'h4321, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out", int'(out), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send0(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1);
        drain();

`ifdef SEQ_ADDER_SUB_EN
        send0(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b1, 1'b1);
        send0(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b0, 1'b1);
        send0(16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0, 1'b1);
        send0(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b1);
        drain();
`endif

        // Single-slice instance: directed then back-to-back random against a+b.
        send1(8'hC0, 8'h80);
        send1(8'hFF, 8'h01);
        for (int i = 0; i < 8; i++) send1(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
